// File: rtl/mems_pkg.sv
// mems_pkg -- shared definitions for the microphone RAM scheduler.
//   N_CH_DEF       default number of microphone channels
//   DEPTH_LOG2_DEF default log2 of per-channel history depth
//   SUM_W          width of the signed delay-and-sum result
//   state_t        frame sequencer states
//   sext_sample    sign-extends one 16-bit sample to SUM_W bits
package mems_pkg;

   localparam int N_CH_DEF       = 6;
   localparam int DEPTH_LOG2_DEF = 7;
   localparam int SUM_W          = 19;
   localparam int SAMPLE_W       = 16;
   localparam int CH_W           = 3;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      DONE
   } state_t;

   function automatic logic [SUM_W-1:0] sext_sample(input logic [SAMPLE_W-1:0] s);
      return {{(SUM_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
   endfunction

endpackage

// File: rtl/mic_ram_sched_if.sv
// mic_ram_sched_if -- single-port sample RAM bus.
//   ram_addr  {channel, slot} address
//   ram_we    write enable
//   ram_wdata write data
//   ram_rdata read data, valid one cycle after the address
// Modports: master (scheduler side), slave (RAM side).
interface mic_ram_sched_if
   import mems_pkg::*;
#(
   parameter int AW = CH_W + DEPTH_LOG2_DEF
);

   logic [AW-1:0]       ram_addr;
   logic                ram_we;
   logic [SAMPLE_W-1:0] ram_wdata;
   logic [SAMPLE_W-1:0] ram_rdata;

   modport master (
      output ram_addr,
      output ram_we,
      output ram_wdata,
      input  ram_rdata
   );

   modport slave (
      input  ram_addr,
      input  ram_we,
      input  ram_wdata,
      output ram_rdata
   );

endinterface

// File: rtl/mic_delay_table.sv
// mic_delay_table -- per-channel delay registers with a per-frame snapshot.
//   ck, rst_n        clock, synchronous active-low reset
//   cfg_we_i         table write strobe
//   cfg_ch_i         channel to write; indices >= N_CH are ignored
//   cfg_delay_i      delay in frames
//   cfg_mask_we_i    channel mask write strobe   (MIC_CHANNEL_MASK_EN only)
//   cfg_mask_i       channel mask, 1 = summed    (MIC_CHANNEL_MASK_EN only)
//   take_i           capture the table for a new frame
//   snap_delay_o     delays frozen for the frame in progress
//   snap_mask_o      mask frozen for the frame (all ones without the macro)
// Optional feature macro: MIC_CHANNEL_MASK_EN.
module mic_delay_table
   import mems_pkg::*;
#(
   parameter int N_CH       = N_CH_DEF,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic                                ck,
   input  logic                                rst_n,
   input  logic                                cfg_we_i,
   input  logic [CH_W-1:0]                     cfg_ch_i,
   input  logic [DEPTH_LOG2-1:0]               cfg_delay_i,
`ifdef MIC_CHANNEL_MASK_EN
   input  logic                                cfg_mask_we_i,
   input  logic [N_CH-1:0]                     cfg_mask_i,
`endif
   input  logic                                take_i,
   output logic [N_CH-1:0][DEPTH_LOG2-1:0]     snap_delay_o,
   output logic [N_CH-1:0]                     snap_mask_o
);

   logic [N_CH-1:0][DEPTH_LOG2-1:0] delay_q, delay_d;
   logic [N_CH-1:0][DEPTH_LOG2-1:0] snap_q, snap_d;
   logic [N_CH-1:0]                 hit;

   // Out-of-range channel indices decode to no hit at all.
   always_comb begin
      hit = '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
         hit[c] = cfg_we_i && (cfg_ch_i == CH_W'(c));
      end
   end

   // Snapshot is taken from the post-write table so a write on the
   // frame-start edge is already visible to that frame.
   always_comb begin
      delay_d = delay_q;
      snap_d  = snap_q;
      for (int unsigned c = 0; c < N_CH; c++) begin
         if (hit[c]) delay_d[c] = cfg_delay_i;
      end
      if (take_i) snap_d = delay_d;
   end

   always_ff @(posedge ck) begin
      if (!rst_n) begin
         delay_q <= '0;
         snap_q  <= '0;
      end else begin
         delay_q <= delay_d;
         snap_q  <= snap_d;
      end
   end

   assign snap_delay_o = snap_q;

`ifdef MIC_CHANNEL_MASK_EN
   logic [N_CH-1:0] mask_q, mask_d;
   logic [N_CH-1:0] smask_q, smask_d;

   always_comb begin
      mask_d  = mask_q;
      smask_d = smask_q;
      if (cfg_mask_we_i) mask_d = cfg_mask_i;
      if (take_i) smask_d = mask_d;
   end

   always_ff @(posedge ck) begin
      if (!rst_n) begin
         mask_q  <= '1;
         smask_q <= '1;
      end else begin
         mask_q  <= mask_d;
         smask_q <= smask_d;
      end
   end

   assign snap_mask_o = smask_q;
`else
   assign snap_mask_o = '1;
`endif

endmodule

// File: rtl/mic_ram_sched.sv
// mic_ram_sched -- delay-and-sum scheduler over a shared single-port RAM.
// Each frame writes every channel's sample at {c, wr_ptr}, then reads
// {c, wr_ptr - delay[c]} and sums the returned samples into sum_out.
//   ck, rst_n    clock, synchronous active-low reset
//   frame_stb    one-cycle pulse, new frame on mic_data
//   mic_data     signed samples, channel c at [16c+15:16c]
//   cfg_we/cfg_ch/cfg_delay  delay table write port
//   cfg_mask_we/cfg_mask     channel mask write port (MIC_CHANNEL_MASK_EN only)
//   ram          RAM bus (master modport)
//   sum_out      signed sum, held between updates
//   sum_valid    one-cycle pulse when sum_out updates
//   busy         frame sequence in progress
//   overrun      sticky, a frame_stb arrived while busy
// Optional feature macro: MIC_CHANNEL_MASK_EN.
module mic_ram_sched
   import mems_pkg::*;
#(
   parameter int N_CH       = N_CH_DEF,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic                       ck,
   input  logic                       rst_n,
   input  logic                       frame_stb,
   input  logic [SAMPLE_W*N_CH-1:0]   mic_data,
   input  logic                       cfg_we,
   input  logic [CH_W-1:0]            cfg_ch,
   input  logic [DEPTH_LOG2-1:0]      cfg_delay,
`ifdef MIC_CHANNEL_MASK_EN
   input  logic                       cfg_mask_we,
   input  logic [N_CH-1:0]            cfg_mask,
`endif
   mic_ram_sched_if.master            ram,
   output logic [SUM_W-1:0]           sum_out,
   output logic                       sum_valid,
   output logic                       busy,
   output logic                       overrun
);

   localparam int AW = CH_W + DEPTH_LOG2;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

   state_t                            state_q, state_d;
   logic [CH_W-1:0]                   cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0]             wr_ptr_q;
   logic [N_CH-1:0][SAMPLE_W-1:0]     samp_q;
   logic                              accept;

   logic [N_CH-1:0][DEPTH_LOG2-1:0]   snap_delay;
   logic [N_CH-1:0]                   snap_mask;

   logic [AW-1:0]                     addr_q, addr_d;
   logic                              we_q, we_d;
   logic [SAMPLE_W-1:0]               wdata_q, wdata_d;
   // Read tag pipeline: *_q tags travel with the address, *v_q with the data.
   logic                              rd_q, rd_d, rdv_q;
   logic                              use_q, use_d, usev_q;
   logic                              last_q, last_d, lastv_q;

   logic [SUM_W-1:0]                  acc_q, sum_q, contrib;
   logic                              sum_valid_q, overrun_q;

   assign accept = frame_stb && (state_q == IDLE);

   mic_delay_table #(
      .N_CH       (N_CH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_table (
      .ck            (ck),
      .rst_n         (rst_n),
      .cfg_we_i      (cfg_we),
      .cfg_ch_i      (cfg_ch),
      .cfg_delay_i   (cfg_delay),
`ifdef MIC_CHANNEL_MASK_EN
      .cfg_mask_we_i (cfg_mask_we),
      .cfg_mask_i    (cfg_mask),
`endif
      .take_i        (accept),
      .snap_delay_o  (snap_delay),
      .snap_mask_o   (snap_mask)
   );

   // State register
   always_ff @(posedge ck) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (frame_stb) begin
               state_d = WRITE;
               cnt_d   = '0;
            end
         end
         WRITE: begin
            if (cnt_q == LAST_CH) begin
               state_d = READ;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CH_W'(1);
            end
         end
         READ: begin
            if (cnt_q == LAST_CH) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CH_W'(1);
            end
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic; RAM-side values are registered one cycle later.
   always_comb begin
      we_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      rd_d    = 1'b0;
      use_d   = 1'b0;
      last_d  = 1'b0;
      busy    = (state_q != IDLE);
      unique case (state_q)
         WRITE: begin
            we_d    = 1'b1;
            addr_d  = {cnt_q, wr_ptr_q};
            wdata_d = samp_q[cnt_q];
         end
         READ: begin
            rd_d   = 1'b1;
            addr_d = {cnt_q, wr_ptr_q - snap_delay[cnt_q]};
            use_d  = snap_mask[cnt_q];
            last_d = (cnt_q == LAST_CH);
         end
         default: ;
      endcase
   end

   assign contrib = usev_q ? sext_sample(ram.ram_rdata) : '0;

   always_ff @(posedge ck) begin
      if (!rst_n) begin
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         rd_q        <= 1'b0;
         use_q       <= 1'b0;
         last_q      <= 1'b0;
         rdv_q       <= 1'b0;
         usev_q      <= 1'b0;
         lastv_q     <= 1'b0;
         samp_q      <= '0;
         wr_ptr_q    <= '0;
         acc_q       <= '0;
         sum_q       <= '0;
         sum_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         rd_q        <= rd_d;
         use_q       <= use_d;
         last_q      <= last_d;
         rdv_q       <= rd_q;
         usev_q      <= use_q;
         lastv_q     <= last_q;
         sum_valid_q <= 1'b0;

         if (accept) begin
            samp_q <= mic_data;
            acc_q  <= '0;
         end
         if (frame_stb && (state_q != IDLE)) overrun_q <= 1'b1;
         if (state_q == DONE) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);

         // The last channel's data folds straight into sum_out.
         if (rdv_q) begin
            if (lastv_q) begin
               sum_q       <= acc_q + contrib;
               sum_valid_q <= 1'b1;
               acc_q       <= '0;
            end else begin
               acc_q <= acc_q + contrib;
            end
         end
      end
   end

   assign ram.ram_addr  = addr_q;
   assign ram.ram_we    = we_q;
   assign ram.ram_wdata = wdata_q;
   assign sum_out       = sum_q;
   assign sum_valid     = sum_valid_q;
   assign overrun       = overrun_q;

endmodule

// File: doc/mic_ram_sched.md
MIC_RAM_SCHED -- requirements
Module: mic_ram_sched

Interface
- REQ-001 SHALL have parameter N_CH, default 6: number of microphone channels.
- REQ-002 SHALL have parameter DEPTH_LOG2, default 7: log2 of the per-channel sample history depth (128).
- REQ-003 SHALL have one clock and a synchronous active-low reset: ck input 1, the single clock; rst_n input 1, active-low, sampled on rising ck.
- REQ-004 frame_stb  input  1: one-cycle pulse, new frame of mic samples valid.
- REQ-005 mic_data  input  16*N_CH: signed samples, channel c at bits [16c+15:16c].
- REQ-006 cfg_we  input  1: delay-table write strobe.
- REQ-007 cfg_ch  input  3: channel index for the table write.
- REQ-008 cfg_delay  input  DEPTH_LOG2: delay in frames for cfg_ch.
- REQ-009 ram_addr  output  3+DEPTH_LOG2: {channel, slot} address to single-port RAM.
- REQ-010 ram_we  output  1: RAM write enable.
- REQ-011 ram_wdata  output  16: RAM write data.
- REQ-012 ram_rdata  input  16: RAM read data, valid one cycle after the address.
- REQ-013 sum_out  output  19: signed delay-and-sum result.
- REQ-014 sum_valid  output  1: one-cycle pulse, sum_out updated.
- REQ-015 busy  output  1: frame sequence in progress.
- REQ-016 overrun  output  1: sticky flag, a frame_stb was dropped.

Function
- REQ-017 SHALL use states IDLE, WRITE, READ, DRAIN, DONE; IDLE->WRITE on frame_stb; WRITE->READ after N_CH cycles; READ->DRAIN after N_CH cycles; DRAIN->DONE after 1 cycle; DONE->IDLE after 1 cycle.
- REQ-018 On frame_stb in IDLE at edge T, SHALL latch mic_data and snapshot the delay table.
- REQ-019 WRITE (T+1..T+N_CH): ram_we=1, addr={c, wr_ptr}, wdata=sample c, for c=0..N_CH-1 in order.
- REQ-020 READ (T+N_CH+1..T+2N_CH): ram_we=0, addr={c, wr_ptr - delay[c]} modulo 2^DEPTH_LOG2.
- REQ-021 SHALL accumulate each ram_rdata the cycle after its address, sign-extended to 19 bits; the accumulator is cleared at frame start.
- REQ-022 SHALL assert sum_valid for exactly one cycle at T+2N_CH+2 (T+14 at default), with sum_out held until the next update.
- REQ-023 In DONE, wr_ptr SHALL increment, wrapping 2^DEPTH_LOG2-1 -> 0.
- REQ-024 Delay 0 SHALL return the sample written in the same frame.
- REQ-025 busy SHALL be 1 in every state except IDLE.
- REQ-026 frame_stb while busy SHALL be ignored and SHALL set overrun, which clears only on reset.
- REQ-027 cfg_we SHALL update the table immediately; the change takes effect from the next frame_stb only, and the current frame uses its snapshot.
- REQ-028 cfg_we together with frame_stb on the same edge: the snapshot SHALL take the new value.
- REQ-029 cfg_ch >= N_CH SHALL be ignored.
- REQ-030 The 19-bit sum SHALL NOT overflow (6 x -32768 = -196608 fits).

Reset
- REQ-031 rst_n=0 SHALL force IDLE, wr_ptr=0, all delays=0, sum_out=0, sum_valid=0, busy=0, overrun=0, ram_we=0, ram_addr=0, ram_wdata=0.
- REQ-032 Reset mid-frame SHALL abort the frame with no sum_valid; RAM contents are undefined-but-harmless.

Configuration
- REQ-033 With MIC_CHANNEL_MASK_EN defined: an N_CH-bit register with default all-ones, written via cfg_we when cfg_delay[DEPTH_LOG2-1]... is not used; instead a cfg_mask_we input and a cfg_mask input of width N_CH; masked channels still write RAM but contribute 0 to the sum.
- REQ-034 Without MIC_CHANNEL_MASK_EN: there are no mask ports and all channels are summed.

Structure
- REQ-035 Package mems_pkg SHALL hold N_CH_DEF=6, DEPTH_LOG2_DEF=7, SUM_W=19, and the state enum.
- REQ-036 A sub-module mic_delay_table SHALL hold the delay registers, the config write port and the snapshot.

Verification
- REQ-037 Reset, all delays 0, one frame with mic = 1..6 -> ram writes at addresses 0,128,..,640; sum_out=21 at T+14.
- REQ-038 delay[2]=3, 5 frames where channel 2 holds the frame number k and the others hold 0 -> sums 0,0,0,1,2 (frames 1-3 read zeroed/pre-written RAM; the bench preloads 0).
- REQ-039 All channels -32768, delays 0 -> sum_out = -196608, no wrap.
- REQ-040 frame_stb at T and T+5 -> one sum_valid and overrun=1; reset -> overrun=0.
- REQ-041 130 frames, delay 127 on channel 0 -> wr_ptr wraps and the read address is computed modulo 128; the output equals the sample from 127 frames earlier.
- REQ-042 cfg_we at T+8 mid-frame -> the current sum is unchanged and the next frame uses the new delay.
